pcma_lock_ctrl: RTL

Frame-level sequencer and lock-decision controller for the PCMA detector's histogram-based lock calculator. It sequences three things per frame:
- clears the boundary histogram,
- counts FRAME_LEN symbol strobes into it,
- fires a single-cycle start pulse into the lock calculator, then waits for its verdict with a timeout.
It applies lock/unlock hysteresis to the raw verdicts and, while unlocked, alternates the calculator mode between FM4 and FM8 after repeated failures.

---
 rtl/pcma_lock_ctrl_if.sv | 27 ++
 rtl/pcma_lock_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pcma_lock_ctrl_if.sv
// Handshake bundle between the PCMA frame sequencer and its surroundings:
// run/strobe/verdict inputs and clear/start/mode/lock/status outputs.
interface pcma_lock_ctrl_if;
  logic       enable_i;
  logic       sym_val_i;
  logic       calc_val_i;
  logic       calc_lock_i;
  logic       hist_clear_o;
  logic       calc_start_o;
  logic [2:0] mode_o;
  logic       lock_o;
  logic       lock_change_o;
  logic       timeout_err_o;
  logic [2:0] state_o;

  modport slave (
    input  enable_i, sym_val_i, calc_val_i, calc_lock_i,
    output hist_clear_o, calc_start_o, mode_o, lock_o, lock_change_o,
           timeout_err_o, state_o
  );

  modport master (
    output enable_i, sym_val_i, calc_val_i, calc_lock_i,
    input  hist_clear_o, calc_start_o, mode_o, lock_o, lock_change_o,
           timeout_err_o, state_o
  );
endinterface

// File: rtl/pcma_lock_ctrl.sv
// PCMA lock controller: per-frame histogram clear/accumulate/start sequencing,
// verdict wait with timeout, lock hysteresis and FM4/FM8 mode hunting.
module pcma_lock_ctrl #(
  parameter int         FRAME_LEN    = 4096,
  parameter int         FRAME_W      = 13,
  parameter int         LOCK_CNT     = 3,
  parameter int         UNLOCK_CNT   = 4,
  parameter int         SWITCH_FAILS = 2,
  parameter int         CNT_W        = 3,
  parameter int         TIMEOUT      = 16,
  parameter int         TO_W         = 5,
  parameter logic [2:0] START_MODE   = 3'b001
) (
  input  logic              clk,
  input  logic              reset,
  pcma_lock_ctrl_if.slave   bus
);

  localparam logic [2:0]         MODE_FM4   = 3'b001;
  localparam logic [2:0]         MODE_FM8   = 3'b010;
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_LEN - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]     LOCK_TH    = (CNT_W+1)'(LOCK_CNT);
  localparam logic [CNT_W:0]     UNLOCK_TH  = (CNT_W+1)'(UNLOCK_CNT);
  localparam logic [CNT_W:0]     SWITCH_TH  = (CNT_W+1)'(SWITCH_FAILS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_ACCUM  = 3'd2,
    ST_START  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_DECIDE = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [CNT_W-1:0]   pass_q, pass_d;
  logic [CNT_W-1:0]   fail_q, fail_d;
  logic               result_q, result_d;
  logic               lock_q, lock_d;
  logic [2:0]         mode_q, mode_d;
  logic               clear_q, clear_d;
  logic               start_q, start_d;
  logic               chg_q, chg_d;
  logic               err_q, err_d;
  logic [CNT_W:0]     pass_nxt, fail_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [2:0] toggle_mode(input logic [2:0] m);
    return (m == MODE_FM4) ? MODE_FM8 : MODE_FM4;
  endfunction

  // Unsaturated next streak lengths, one bit wider so thresholds compare cleanly
  assign pass_nxt = {1'b0, pass_q} + (CNT_W+1)'(1);
  assign fail_nxt = {1'b0, fail_q} + (CNT_W+1)'(1);

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    to_d     = to_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    result_d = result_q;
    lock_d   = lock_q;
    mode_d   = mode_q;
    chg_d    = 1'b0;
    err_d    = 1'b0;

    if (!bus.enable_i && (state_q != ST_IDLE)) begin
      // Abort: drop lock, keep the hunted mode for the next run
      state_d  = ST_IDLE;
      frame_d  = '0;
      to_d     = '0;
      pass_d   = '0;
      fail_d   = '0;
      result_d = 1'b0;
      lock_d   = 1'b0;
      chg_d    = lock_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.enable_i) state_d = ST_CLEAR;
        end
        ST_CLEAR: begin
          frame_d = '0;
          state_d = ST_ACCUM;
        end
        ST_ACCUM: begin
          if (bus.sym_val_i) begin
            frame_d = frame_q + FRAME_W'(1);
            if (frame_q == FRAME_LAST) state_d = ST_START;
          end
        end
        ST_START: begin
          to_d    = '0;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.calc_val_i) begin
            result_d = bus.calc_lock_i;
            state_d  = ST_DECIDE;
          end else if (to_q == TO_LAST) begin
            result_d = 1'b0;
            err_d    = 1'b1;
            state_d  = ST_DECIDE;
          end else begin
            to_d = to_q + TO_W'(1);
          end
        end
        ST_DECIDE: begin
          if (result_q) begin
            fail_d = '0;
            pass_d = sat_inc(pass_q);
            if (!lock_q && (pass_nxt >= LOCK_TH)) begin
              lock_d = 1'b1;
              chg_d  = 1'b1;
            end
          end else begin
            pass_d = '0;
            fail_d = sat_inc(fail_q);
            if (lock_q) begin
              if (fail_nxt >= UNLOCK_TH) begin
                lock_d = 1'b0;
                chg_d  = 1'b1;
                fail_d = '0;
              end
            end else if (fail_nxt >= SWITCH_TH) begin
              mode_d = toggle_mode(mode_q);
              fail_d = '0;
            end
          end
          state_d = ST_CLEAR;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Pulses are registered so they line up with the state they belong to
    clear_d = (state_d == ST_CLEAR);
    start_d = (state_d == ST_START);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      frame_q  <= '0;
      to_q     <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      result_q <= 1'b0;
      lock_q   <= 1'b0;
      mode_q   <= START_MODE;
      clear_q  <= 1'b0;
      start_q  <= 1'b0;
      chg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      to_q     <= to_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      result_q <= result_d;
      lock_q   <= lock_d;
      mode_q   <= mode_d;
      clear_q  <= clear_d;
      start_q  <= start_d;
      chg_q    <= chg_d;
      err_q    <= err_d;
    end
  end

  assign bus.hist_clear_o  = clear_q;
  assign bus.calc_start_o  = start_q;
  assign bus.mode_o        = mode_q;
  assign bus.lock_o        = lock_q;
  assign bus.lock_change_o = chg_q;
  assign bus.timeout_err_o = err_q;
  assign bus.state_o       = state_q;

endmodule
